// File: rtl/gpool_stream_layer.sv
// Streaming global pooling layer: reduces ACTIVATIONS_GMP beats per frame to one max or scaled-average value per class.
// Optional feature macro GPOOL_ARGMAX_EN adds an argmax output over the pooled result.
module gpool_stream_layer #(
  parameter int BIT_SIZE        = 16,
  parameter int ACTIVATIONS_GMP = 36,
  parameter int NUM_CLASSES     = 10,
  parameter int AVG_SHIFT       = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CLASSES*BIT_SIZE-1:0] in_data,
  input  logic                            in_valid,
  input  logic                            in_last,
  output logic                            in_ready,
  input  logic                            mode,
  output logic [NUM_CLASSES*BIT_SIZE-1:0] out,
  output logic                            out_valid,
  input  logic                            out_ready,
`ifdef GPOOL_ARGMAX_EN
  output logic [$clog2(NUM_CLASSES)-1:0]  argmax,
`endif
  output logic                            frame_err
);

  localparam int CNT_W = $clog2(ACTIVATIONS_GMP);
  localparam int ACC_W = BIT_SIZE + CNT_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACTIVATIONS_GMP - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (BIT_SIZE - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]              state;
  logic [CNT_W-1:0]        cnt;
  logic                    mode_q;
  logic signed [ACC_W-1:0] acc      [NUM_CLASSES];
  logic signed [ACC_W-1:0] beat_ext [NUM_CLASSES];
  logic signed [ACC_W-1:0] next_acc [NUM_CLASSES];
  logic signed [ACC_W-1:0] shifted  [NUM_CLASSES];
  logic signed [BIT_SIZE-1:0] pooled [NUM_CLASSES];
  logic [NUM_CLASSES*BIT_SIZE-1:0] out_next;
  logic                    last_beat;

  assign in_ready  = (state == ACCUM);
  assign last_beat = (cnt == LAST_CNT);

  // The first beat of a frame loads the accumulator, so a frame of all-negative inputs pools correctly.
  always_comb begin
    out_next = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      beat_ext[c] = {{CNT_W{in_data[c*BIT_SIZE+BIT_SIZE-1]}}, in_data[c*BIT_SIZE +: BIT_SIZE]};
      if (cnt == '0)
        next_acc[c] = beat_ext[c];
      else if (mode_q)
        next_acc[c] = acc[c] + beat_ext[c];
      else
        next_acc[c] = (beat_ext[c] > acc[c]) ? beat_ext[c] : acc[c];

      shifted[c] = next_acc[c] >>> AVG_SHIFT;
      if (!mode_q)
        pooled[c] = next_acc[c][BIT_SIZE-1:0];
      else if (shifted[c] > SAT_MAX)
        pooled[c] = SAT_MAX[BIT_SIZE-1:0];
      else if (shifted[c] < SAT_MIN)
        pooled[c] = SAT_MIN[BIT_SIZE-1:0];
      else
        pooled[c] = shifted[c][BIT_SIZE-1:0];

      out_next[c*BIT_SIZE +: BIT_SIZE] = pooled[c];
    end
  end

`ifdef GPOOL_ARGMAX_EN
  logic [$clog2(NUM_CLASSES)-1:0] best_idx;
  logic signed [BIT_SIZE-1:0]     best_val;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_val = pooled[0];
    for (int c = 1; c < NUM_CLASSES; c++) begin
      if (pooled[c] > best_val) begin
        best_val = pooled[c];
        best_idx = ($clog2(NUM_CLASSES))'(c);
      end
    end
  end
`endif

  // Frame length is always set by the counter; in_last only feeds the mismatch flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ACCUM;
      cnt       <= '0;
      mode_q    <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= '0;
`ifdef GPOOL_ARGMAX_EN
      argmax    <= '0;
`endif
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= next_acc[c];
            if (cnt == '0) mode_q <= mode;
            if (in_last != last_beat) frame_err <= 1'b1;
            if (last_beat) begin
              cnt       <= '0;
              out       <= out_next;
              out_valid <= 1'b1;
              state     <= HOLD;
`ifdef GPOOL_ARGMAX_EN
              argmax    <= best_idx;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
